// File: rtl/vs_hex_word_parser.sv
// ----------------------------------------------------------------------------
// vs_hex_word_parser
//
// Purpose:
//   Assembles ASCII hexadecimal digits arriving from a UART receiver into a
//   binary word. A carriage return (0x0D) terminates a word. Malformed words
//   (illegal characters or too many digits) raise a one-cycle ERR pulse, and
//   the rest of the word up to the next CR is then discarded silently.
//
// Parameters:
//   N_DIGITS    - maximum hex digits per word; WORD is 4*N_DIGITS bits wide.
//   TIMEOUT_CYC - idle cycles after which a partial word is abandoned
//                 (only meaningful when VS_HEX_TIMEOUT_EN is defined).
//
// Build option:
//   VS_HEX_TIMEOUT_EN - when defined, an idle-cycle counter abandons a
//                       partially received or discarded word after
//                       TIMEOUT_CYC cycles without a byte. When undefined,
//                       no timeout hardware exists and partial words wait
//                       indefinitely.
//
// Ports:
//   CLK      in   1           rising-edge clock
//   RST      in   1           asynchronous, active-high reset
//   RX_DATA  in   8           ASCII byte from the UART receiver
//   RX_VLD   in   1           one-cycle strobe qualifying RX_DATA
//   WORD     out  4*N_DIGITS  last completed word, zero-extended
//   WORD_VLD out  1           one-cycle pulse when WORD is updated
//   ERR      out  1           one-cycle pulse on a malformed word
//   BUSY     out  1           high while collecting or discarding a word
// ----------------------------------------------------------------------------
module vs_hex_word_parser #(
  parameter int N_DIGITS    = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [7:0]              RX_DATA,
  input  logic                    RX_VLD,
  output logic [4*N_DIGITS-1:0]   WORD,
  output logic                    WORD_VLD,
  output logic                    ERR,
  output logic                    BUSY
);

  localparam int W     = 4 * N_DIGITS;
  // Count runs 0..N_DIGITS, so it needs room for N_DIGITS itself.
  localparam int CNT_W = $clog2(N_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;

  // --------------------------------------------------------------------------
  // Byte classification helpers
  // --------------------------------------------------------------------------
  function automatic logic is_dec_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_hex_digit(input logic [7:0] b);
    return is_dec_digit(b) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // 'A' (0x41) and 'a' (0x61) both have low nibble 1, so adding 9 to the
  // low nibble maps either letter case onto 10..15.
  function automatic logic [3:0] hex_value(input logic [7:0] b);
    if (is_dec_digit(b)) begin
      return b[3:0];
    end
    return b[3:0] + 4'd9;
  endfunction

  // Shift the accumulator up one nibble and insert the new digit at the bottom.
  function automatic logic [W-1:0] acc_push(input logic [W-1:0] acc,
                                            input logic [3:0]   dig);
    logic [W-1:0] tmp;
    tmp      = acc << 4;
    tmp[3:0] = dig;
    return tmp;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q,    state_d;
  logic [W-1:0]     acc_q,      acc_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [W-1:0]     word_q,     word_d;
  logic             word_vld_q, word_vld_d;
  logic             err_q,      err_d;

  logic             rx_digit;
  logic             rx_cr;
  logic [3:0]       rx_val;
  logic             busy;

  assign rx_digit = is_hex_digit(RX_DATA);
  assign rx_cr    = (RX_DATA == ASCII_CR);
  assign rx_val   = hex_value(RX_DATA);
  assign busy     = (state_q != IDLE);

`ifdef VS_HEX_TIMEOUT_EN
  // Counter width holds TIMEOUT_CYC-1 even for TIMEOUT_CYC == 1.
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_q, to_d;
  logic            to_expire;

  // Expiry fires on the TIMEOUT_CYC-th consecutive idle cycle while busy.
  // A byte arriving in the same cycle always wins, so RX_VLD masks expiry.
  assign to_expire = busy && !RX_VLD && (to_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    to_d = to_q + TO_W'(1);
    if (!busy || RX_VLD || to_expire) begin
      to_d = '0;
    end
  end
`else
  // Partial words wait indefinitely; TIMEOUT_CYC carries no hardware here.
  if (TIMEOUT_CYC < 1) begin : g_timeout_param_unused
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    err_d      = 1'b0;

    if (RX_VLD) begin
      case (state_q)
        IDLE: begin
          if (rx_digit) begin
            acc_d   = {{(W-4){1'b0}}, rx_val};
            cnt_d   = CNT_W'(1);
            state_d = COLLECT;
          end else if (!rx_cr) begin
            err_d   = 1'b1;
            state_d = DISCARD;
          end
        end

        COLLECT: begin
          if (rx_cr) begin
            word_d     = acc_q;
            word_vld_d = 1'b1;
            state_d    = IDLE;
          end else if (rx_digit && (cnt_q < CNT_W'(N_DIGITS))) begin
            acc_d = acc_push(acc_q, rx_val);
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            // Illegal character, or a digit beyond the word capacity.
            err_d   = 1'b1;
            state_d = DISCARD;
          end
        end

        DISCARD: begin
          if (rx_cr) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
`ifdef VS_HEX_TIMEOUT_EN
    else if (to_expire) begin
      // Only an abandoned word in progress is reported; an abandoned
      // discard was already reported when it started.
      err_d   = (state_q == COLLECT);
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      err_q      <= err_d;
    end
  end

`ifdef VS_HEX_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  assign WORD     = word_q;
  assign WORD_VLD = word_vld_q;
  assign ERR      = err_q;
  assign BUSY     = busy;

endmodule

// File: tb/tb_vs_hex_word_parser.sv
module tb_vs_hex_word_parser;

  localparam int N_DIG = 4;
  localparam int W     = 4 * N_DIG;
  localparam int TO    = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [7:0]   RX_DATA = 8'h00;
  logic         RX_VLD = 1'b0;
  logic [W-1:0] WORD;
  logic         WORD_VLD;
  logic         ERR;
  logic         BUSY;

  int tests = 0;
  int fails = 0;

  vs_hex_word_parser #(
    .N_DIGITS    (N_DIG),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_DATA  (RX_DATA),
    .RX_VLD   (RX_VLD),
    .WORD     (WORD),
    .WORD_VLD (WORD_VLD),
    .ERR      (ERR),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference model: the word in progress is a list of digit values; a
  // separate flag says the rest of a bad word is being thrown away.
  int           digits[$];
  bit           discarding = 0;
  int           idle_edges = 0;
  logic [W-1:0] exp_word = '0;
  bit           exp_vld = 0;
  bit           exp_err = 0;

  function automatic bit m_busy();
    return discarding || (digits.size() > 0);
  endfunction

  // -1 illegal, -2 carriage return, otherwise digit value.
  function automatic int classify(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    if (b == 8'h0D) return -2;
    return -1;
  endfunction

  function automatic logic [W-1:0] digits_value();
    logic [W-1:0] v;
    v = '0;
    foreach (digits[i]) v = v * 16 + W'(digits[i]);
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int v;
    v = classify(b);
    exp_vld    = 0;
    exp_err    = 0;
    idle_edges = 0;
    if (discarding) begin
      if (v == -2) discarding = 0;
    end else if (digits.size() == 0) begin
      if (v >= 0) digits.push_back(v);
      else if (v == -1) begin exp_err = 1; discarding = 1; end
    end else begin
      if (v == -2) begin
        exp_word = digits_value();
        exp_vld  = 1;
        digits.delete();
      end else if (v == -1 || digits.size() == N_DIG) begin
        exp_err    = 1;
        discarding = 1;
        digits.delete();
      end else begin
        digits.push_back(v);
      end
    end
  endtask

  task automatic check(input string tag);
    tests++;
    assert (WORD_VLD === exp_vld) else begin
      fails++;
      $error("FAIL %s WORD_VLD got %0b expected %0b", tag, WORD_VLD, exp_vld);
    end
    tests++;
    assert (ERR === exp_err) else begin
      fails++;
      $error("FAIL %s ERR got %0b expected %0b", tag, ERR, exp_err);
    end
    tests++;
    assert (BUSY === m_busy()) else begin
      fails++;
      $error("FAIL %s BUSY got %0b expected %0b", tag, BUSY, m_busy());
    end
    tests++;
    assert (WORD === exp_word) else begin
      fails++;
      $error("FAIL %s WORD got %h expected %h", tag, WORD, exp_word);
    end
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] want);
    tests++;
    assert (WORD === want) else begin
      fails++;
      $error("FAIL %s WORD got %h expected %h", tag, WORD, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    @(negedge CLK);
    RX_DATA = b;
    RX_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_VLD  = 1'b0;
    model_byte(b);
    check(tag);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) begin
      @(posedge CLK);
      #1;
      exp_vld = 0;
      exp_err = 0;
`ifdef VS_HEX_TIMEOUT_EN
      if (m_busy()) begin
        idle_edges++;
        if (idle_edges == TO) begin
          exp_err    = (digits.size() > 0);
          discarding = 0;
          digits.delete();
          idle_edges = 0;
        end
      end
`endif
      check(tag);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    digits.delete();
    discarding = 0;
    idle_edges = 0;
    exp_word   = '0;
    exp_vld    = 0;
    exp_err    = 0;
    check(tag);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check({tag, "_rel"});
  endtask

  function automatic logic [7:0] rand_byte();
    string hexchars;
    int    r;
    logic [7:0] b;
    hexchars = "0123456789ABCDEFabcdef";
    r = $urandom_range(0, 99);
    if (r < 70) return hexchars[$urandom_range(0, 21)];
    if (r < 85) return 8'h0D;
    b = 8'h47;
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom_range(0, 255));
      if (classify(b) == -1) return b;
    end
    return 8'h47;
  endfunction

  initial begin
    // Reset state
    RST = 1'b1;
    #1;
    check("reset_state");
    @(negedge CLK);
    RST = 1'b0;
    idle(2, "post_reset_idle");

    // Mixed-case word
    send_str("1A3f", "w1a3f");
    send_byte(8'h0D, "w1a3f_cr");
    check_word("w1a3f_const", 16'h1A3F);
    idle(1, "w1a3f_pulse_end");

    // Single digit, then a lone CR in IDLE
    send_str("7", "w7");
    send_byte(8'h0D, "w7_cr");
    check_word("w7_const", 16'h0007);
    send_byte(8'h0D, "lone_cr");
    idle(2, "lone_cr_idle");

    // Overflow: fifth digit errors, word unchanged
    send_str("12345", "ovf");
    send_byte(8'h0D, "ovf_cr");
    check_word("ovf_keep", 16'h0007);
    idle(1, "ovf_idle");

    // Illegal character, then a good word
    send_str("1G2", "illegal");
    send_byte(8'h0D, "illegal_cr");
    send_str("BEEF", "beef");
    send_byte(8'h0D, "beef_cr");
    check_word("beef_const", 16'hBEEF);

    // Illegal byte straight from IDLE, including a digit while discarding
    send_str("Z9", "idle_illegal");
    send_byte(8'h0D, "idle_illegal_cr");

    // Reset mid-word
    send_str("AB", "mid_rst");
    do_reset("mid_rst_rst");
    send_str("C", "after_rst");
    send_byte(8'h0D, "after_rst_cr");
    check_word("after_rst_const", 16'h000C);

`ifdef VS_HEX_TIMEOUT_EN
    send_str("9", "to_collect");
    idle(TO, "to_collect_idle");
    send_str("5", "to_next");
    send_byte(8'h0D, "to_next_cr");
    check_word("to_next_const", 16'h0005);
    send_str("X", "to_discard");
    idle(TO + 2, "to_discard_idle");
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      send_byte(rand_byte(), "rand");
      if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3), "rand_gap");
      if ($urandom_range(0, 99) < 2) idle(TO + 2, "rand_long_gap");
      if ($urandom_range(0, 99) < 2) do_reset("rand_rst");
    end
    idle(3, "final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
